// File: rtl/mean_pkg.sv
// Shared types and default parameter values for the mean_arbiter block.
package mean_pkg;

  // Controller phases: wait for a request, collect one burst, emit its average.
  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StEmit
  } state_e;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefAccWidth = 33;
  localparam int unsigned DefN        = 1;
  localparam int unsigned DefNch      = 4;
  localparam int unsigned DefTimeout  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last-served index.
module rr_arbiter #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req_i,
  input  logic [$clog2(NCH)-1:0] last_i,
  output logic [NCH-1:0]         gnt_o,
  output logic [$clog2(NCH)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(NCH);

  int unsigned pos;

  // Scan from farthest to nearest so the nearest requester after last_i wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = 0;
    for (int unsigned k = NCH; k >= 1; k--) begin
      pos = (32'(last_i) + k) % NCH;
      if (req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/mean_arbiter.sv
// Multi-channel burst averager: one shared accumulator serves a round-robin
// granted channel for 2^N samples, then emits sum >> N with the channel index.
// Optional stall timeout enabled by defining MEAN_ARBITER_TIMEOUT_EN.
module mean_arbiter
  import mean_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned N         = DefN,
  parameter int unsigned NCH       = DefNch,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             i_vld,
  input  logic [NCH-1:0][WIDTH-1:0]  i_data,
  output logic [NCH-1:0]             o_rdy,
  output logic                       o_vld,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(NCH)-1:0]     o_ch,
  output logic                       o_err
);

  localparam int unsigned IdxW = $clog2(NCH);

  if (ACC_WIDTH < WIDTH + N || N < 1 || NCH < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mean_arbiter: illegal parameter combination");
  end

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        g_q, g_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic [N-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [IdxW-1:0]        ch_q, ch_d;

  logic [NCH-1:0]         rr_gnt;
  logic [IdxW-1:0]        rr_idx;
  logic                   hs;
  logic [ACC_WIDTH-1:0]   sum_add;

`ifdef MEAN_ARBITER_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(TIMEOUT - 1);
  logic [StallW-1:0]      stall_q, stall_d;
  logic                   err_q, err_d;
`endif

  rr_arbiter #(
    .NCH(NCH)
  ) u_rr (
    .req_i (i_vld),
    .last_i(last_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  assign hs      = (state_q == StBurst) && i_vld[g_q];
  assign sum_add = sum_q + ACC_WIDTH'(i_data[g_q]);

  // Next-state logic for the burst controller and result registers.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ch_d    = ch_q;
`ifdef MEAN_ARBITER_TIMEOUT_EN
    stall_d = stall_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (|rr_gnt) begin
          g_d     = rr_idx;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StBurst;
`ifdef MEAN_ARBITER_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      StBurst: begin
        if (hs) begin
          sum_d = sum_add;
          cnt_d = cnt_q + 1'b1;
`ifdef MEAN_ARBITER_TIMEOUT_EN
          stall_d = '0;
`endif
          // Result is latched here so o_data is already valid in the emit cycle.
          if (cnt_q == '1) begin
            data_d  = WIDTH'(sum_add >> N);
            ch_d    = g_q;
            state_d = StEmit;
          end
        end
`ifdef MEAN_ARBITER_TIMEOUT_EN
        else if (stall_q == StallMax) begin
          err_d   = 1'b1;
          last_d  = g_q;
          state_d = StIdle;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      StEmit: begin
        last_d  = g_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= '0;
      last_q  <= IdxW'(NCH - 1);
      sum_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
`ifdef MEAN_ARBITER_TIMEOUT_EN
      stall_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
`ifdef MEAN_ARBITER_TIMEOUT_EN
      stall_q <= stall_d;
      err_q   <= err_d;
`endif
    end
  end

  // Only the granted channel sees ready, and only while collecting.
  always_comb begin
    o_rdy = '0;
    if (state_q == StBurst) o_rdy[g_q] = 1'b1;
  end

  assign o_vld  = (state_q == StEmit);
  assign o_data = data_q;
  assign o_ch   = ch_q;
`ifdef MEAN_ARBITER_TIMEOUT_EN
  assign o_err  = err_q;
`else
  assign o_err  = 1'b0;
`endif

endmodule
